// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: streams one frame from the pixel buffer into the CNN core,
// then waits for its decision (or a timeout) and reports result and latency.
module cnn_frame_sequencer #(
  parameter int IMG_PIXELS     = 784,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 6250
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [7:0]        pix_rdata,
  output logic [7:0]        core_data_in,
  output logic              core_data_valid,
  input  logic [3:0]        core_decision,
  input  logic              core_out_valid,
  output logic              busy,
  output logic [3:0]        result,
  output logic              result_valid,
  output logic [15:0]       latency_cycles,
  output logic              timeout_err
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_PIXELS - 1);
  localparam logic [TW-1:0]     LAST_WT  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            nxt;
  logic              issue;
  logic              rd_vld;
  logic [ADDR_W-1:0] beat_cnt;
  logic [15:0]       lat_cnt;
  logic [TW-1:0]     wait_cnt;
  logic              go;
  logic              cap;
  logic              expire;

  assign go     = (state == S_IDLE) && start;
  assign cap    = (state == S_WAIT) && core_out_valid;
  assign expire = (state == S_WAIT) && !core_out_valid
                  && (wait_cnt == LAST_WT);
  assign busy   = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic; a decision in the expiry cycle takes priority.
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (start) nxt = S_FEED;
      S_FEED: if (core_data_valid && beat_cnt == LAST_PIX) nxt = S_WAIT;
      S_WAIT: begin
        if (core_out_valid)          nxt = S_DONE;
        else if (wait_cnt == LAST_WT) nxt = S_IDLE;
      end
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Address issue, two-stage read pipeline and beat counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_addr        <= '0;
      issue           <= 1'b0;
      rd_vld          <= 1'b0;
      core_data_valid <= 1'b0;
      core_data_in    <= '0;
      beat_cnt        <= '0;
    end else begin
      if (go) begin
        pix_addr <= '0;
        issue    <= 1'b1;
      end else if (issue) begin
        if (pix_addr == LAST_PIX) issue    <= 1'b0;
        else                      pix_addr <= pix_addr + 1'b1;
      end
      rd_vld          <= issue;
      core_data_valid <= rd_vld;
      core_data_in    <= rd_vld ? pix_rdata : 8'h00;
      if (go)                   beat_cnt <= '0;
      else if (core_data_valid) beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Latency and WAIT-timeout counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt  <= '0;
      wait_cnt <= '0;
    end else begin
      if (go)
        lat_cnt <= '0;
      else if ((core_data_valid || state == S_WAIT) && lat_cnt != 16'hFFFF)
        lat_cnt <= lat_cnt + 16'd1;
      if (state == S_WAIT && nxt == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                                  wait_cnt <= '0;
    end
  end

  // Result capture and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      result         <= '0;
      result_valid   <= 1'b0;
      latency_cycles <= '0;
      timeout_err    <= 1'b0;
    end else begin
      result_valid <= cap;
      if (cap) begin
        result         <= core_decision;
        latency_cycles <= lat_cnt;
      end
      if (go)          timeout_err <= 1'b0;
      else if (expire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cnn_frame_sequencer.sv
// tb_cnn_frame_sequencer: frame-level reference model for cnn_frame_sequencer,
// covering nominal, timeout, busy-start, reset, spurious and tie cases.
module tb_cnn_frame_sequencer;

  localparam int N  = 784;
  localparam int AW = 10;
  localparam int TO = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] pix_addr;
  logic [7:0]    pix_rdata;
  logic [7:0]    core_data_in;
  logic          core_data_valid;
  logic [3:0]    core_decision;
  logic          core_out_valid;
  logic          busy;
  logic [3:0]    result;
  logic          result_valid;
  logic [15:0]   latency_cycles;
  logic          timeout_err;

  logic [7:0] mem [1024];
  int errs   = 0;
  int checks = 0;
  logic [3:0]  res_e;
  logic [15:0] lat_e;
  logic        terr_e;

  cnn_frame_sequencer #(
    .IMG_PIXELS(N), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .pix_addr(pix_addr), .pix_rdata(pix_rdata),
    .core_data_in(core_data_in), .core_data_valid(core_data_valid),
    .core_decision(core_decision), .core_out_valid(core_out_valid),
    .busy(busy), .result(result), .result_valid(result_valid),
    .latency_cycles(latency_cycles), .timeout_err(timeout_err)
  );

  always #4 clk = ~clk;

  always @(posedge clk) pix_rdata <= mem[pix_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".addr"}, 32'(pix_addr), 0);
    chk({tag, ".data"}, 32'(core_data_in), 0);
    chk({tag, ".valid"}, 32'(core_data_valid), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".result"}, 32'(result), 0);
    chk({tag, ".rvalid"}, 32'(result_valid), 0);
    chk({tag, ".lat"}, 32'(latency_cycles), 0);
    chk({tag, ".terr"}, 32'(timeout_err), 0);
  endtask

  // d: response delay after the last beat (0 = never); spur: cycle of a
  // stray core_out_valid; bstart: extra starts while busy; rst_at: reset cycle.
  task automatic run_frame(input int d, input logic [3:0] dec, input int spur,
                           input bit bstart, input int rst_at);
    int  last;
    int  tend;
    bit  ev;
    int  ea;
    last = N + 1;
    if (rst_at >= 0)  tend = rst_at + 1;
    else if (d > 0)   tend = last + d + 3;
    else              tend = last + TO + 3;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    terr_e = 1'b0;
    for (int i = 0; i <= tend; i++) begin
      if (i > 0) @(negedge clk);
      if (rst_at >= 0 && i == rst_at + 1) begin
        chk_zero("reset_mid");
        res_e  = '0;
        lat_e  = '0;
        terr_e = 1'b0;
      end else begin
        ev = (i >= 2) && (i <= last);
        ea = (i < N) ? i : N - 1;
        if (d > 0 && i == last + d + 1) begin
          res_e = dec;
          lat_e = 16'(N - 1 + d);
        end
        if (d == 0 && i == last + TO + 1) terr_e = 1'b1;
        chk("valid", 32'(core_data_valid), 32'(ev));
        chk("data", 32'(core_data_in), ev ? 32'(mem[i-2]) : 0);
        chk("addr", 32'(pix_addr), 32'(ea));
        chk("rvalid", 32'(result_valid),
            32'(d > 0 && i == last + d + 1));
        chk("busy", 32'(busy),
            32'((d > 0) ? (i <= last + d + 1) : (i <= last + TO)));
        chk("result", 32'(result), 32'(res_e));
        chk("latency", 32'(latency_cycles), 32'(lat_e));
        chk("terr", 32'(timeout_err), 32'(terr_e));
      end
      core_out_valid = (d > 0 && i == last + d) || (i == spur);
      core_decision  = (d > 0 && i == last + d) ? dec : 4'($urandom);
      start = bstart && (i == 12 || i == 502 ||
                         (d > 0 && i == last + d + 1));
      rst   = (i == rst_at);
    end
    start          = 1'b0;
    rst            = 1'b0;
    core_out_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    start          = 1'b0;
    core_decision  = '0;
    core_out_valid = 1'b0;
    res_e          = '0;
    lat_e          = '0;
    terr_e         = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    // stray decision while idle must be ignored
    core_out_valid = 1'b1;
    @(negedge clk);
    core_out_valid = 1'b0;
    chk("idle_rvalid", 32'(result_valid), 0);

    run_frame(100, 4'd7, -1, 1'b0, -1);
    chk("nominal_lat", 32'(latency_cycles), 883);
    run_frame(0, 4'd0, -1, 1'b0, -1);
    run_frame(int'($urandom_range(1, TO)), 4'($urandom), -1, 1'b1, -1);
    run_frame(0, 4'd0, -1, 1'b0, 302);
    run_frame(50, 4'd5, -1, 1'b0, -1);
    run_frame(30, 4'd3, 52, 1'b0, -1);
    run_frame(TO, 4'd9, -1, 1'b0, -1);

    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0)
        run_frame(0, 4'd0, int'($urandom_range(0, N)), 1'b1, -1);
      else
        run_frame(int'($urandom_range(1, TO)), 4'($urandom),
                  int'($urandom_range(0, N)), 1'($urandom), -1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/cnn_frame_sequencer.md
CNN_FRAME_SEQUENCER -- requirements
Module: cnn_frame_sequencer

Interface
REQ-001 SHALL have parameter IMG_PIXELS, default 784, number of pixels per frame (28x28).
REQ-002 SHALL have parameter ADDR_W, default 10, pixel-buffer address width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 6250, maximum WAIT cycles before abort (50 us at 125 MHz).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  frame request pulse, sampled in IDLE only.
REQ-007 SHALL have port pix_addr  output  ADDR_W  read address to the frame buffer.
REQ-008 SHALL have port pix_rdata  input  8  frame buffer read data, valid exactly 1 cycle after pix_addr.
REQ-009 SHALL have port core_data_in  output  8  pixel to cnn_core_top data_in.
REQ-010 SHALL have port core_data_valid  output  1  to cnn_core_top data_valid.
REQ-011 SHALL have port core_decision  input  4  from cnn_core_top decision.
REQ-012 SHALL have port core_out_valid  input  1  from cnn_core_top out_valid.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port result  output  4  captured decision.
REQ-015 SHALL have port result_valid  output  1  one-cycle pulse when result updates.
REQ-016 SHALL have port latency_cycles  output  16  measured frame latency.
REQ-017 SHALL have port timeout_err  output  1  sticky abort flag.

Function
REQ-018 SHALL implement FSM states IDLE, FEED, WAIT, DONE.
REQ-019 IDLE->FEED SHALL occur when start=1 is sampled; timeout_err SHALL clear on that same edge.
REQ-020 In FEED, the block SHALL issue addresses 0..IMG_PIXELS-1, one per cycle, then hold.
REQ-021 core_data_valid SHALL be high for exactly IMG_PIXELS consecutive cycles; the first beat SHALL be 2 cycles after the start edge.
REQ-022 On beat k, core_data_in SHALL equal buffer[k] (registered pix_rdata).
REQ-023 FEED->WAIT SHALL occur on the edge that ends the last beat; core_data_valid and core_data_in SHALL be 0 outside beats.
REQ-024 A 16-bit latency counter SHALL be 0 on the first beat, increment every cycle thereafter, and saturate at 16'hFFFF.
REQ-025 In WAIT, core_out_valid=1 SHALL load result<=core_decision and latency_cycles<=counter, pulse result_valid for 1 cycle, and enter DONE.
REQ-026 DONE SHALL last 1 cycle and then go to IDLE; start during DONE SHALL be ignored.
REQ-027 In WAIT, if core_out_valid has not arrived after TIMEOUT_CYCLES cycles, the block SHALL set timeout_err, leave result and latency_cycles unchanged, and go to IDLE.
REQ-028 core_out_valid in IDLE, FEED or DONE SHALL be ignored.
REQ-029 start while busy=1 SHALL be ignored and SHALL NOT queue a request.
REQ-030 If core_out_valid and timeout expiry occur in the same cycle, core_out_valid SHALL win.
REQ-031 result and latency_cycles SHALL hold until the next successful capture.

Reset
REQ-032 On any edge with rst=1, the FSM SHALL go to IDLE and all outputs SHALL be 0 on the following cycle: pix_addr, core_data_in, core_data_valid, busy, result, result_valid, latency_cycles, timeout_err.
REQ-033 Reset mid-FEED SHALL drop core_data_valid on the next cycle with no further beats, and SHALL clear all counters.

Verification
REQ-034 Nominal: buffer[i]=i[7:0]; the core model raises core_out_valid with decision=7 100 cycles after the last beat -> 784 beats with data 00..FF repeating, then result=7, latency_cycles=883, one result_valid pulse, busy low 2 cycles after capture.
REQ-035 Timeout: TIMEOUT_CYCLES=200, no core_out_valid -> timeout_err=1 exactly 200 cycles after WAIT entry, busy=0, result/latency unchanged; the next start clears timeout_err.
REQ-036 Busy start: start pulsed at beats 10 and 500, and in DONE -> still exactly 784 beats for one frame; a start one cycle after busy falls produces a second full frame.
REQ-037 Reset mid-feed: rst at beat 300 -> core_data_valid=0 the next cycle and all outputs 0; a subsequent start gives 784 beats beginning at address 0.
REQ-038 Spurious: core_out_valid pulsed during FEED at beat 50 -> no result_valid; the real core_out_valid in WAIT with decision=3 -> result=3.
REQ-039 Simultaneous: core_out_valid on the expiry cycle with decision=9 -> result=9, timeout_err=0.
